// File: rtl/alarm_access_fsm_if.sv
// Request/status bundle between the debounce stage and the access-control core.
// The master drives PIN requests and the slave (the core) returns state and event strobes.
interface alarm_access_fsm_if #(
    parameter int PIN_W = 4
);
    logic [PIN_W-1:0] i_pin;
    logic             i_set;
    logic             i_try;
    logic             i_lock;
    logic [2:0]       o_system_state;
    logic [3:0]       o_fail_cnt;
    logic             o_alarm;
    logic             o_pin_valid;
    logic             o_evt_valid;
    logic [2:0]       o_evt_code;

    modport master (
        output i_pin, i_set, i_try, i_lock,
        input  o_system_state, o_fail_cnt, o_alarm, o_pin_valid, o_evt_valid, o_evt_code
    );

    modport slave (
        input  i_pin, i_set, i_try, i_lock,
        output o_system_state, o_fail_cnt, o_alarm, o_pin_valid, o_evt_valid, o_evt_code
    );
endinterface

// File: rtl/alarm_access_fsm.sv
// Access-control core: master PIN store, failed-attempt counter, alarm lockout and event strobe.
// Define ALARM_RELOCK_EN to auto-relock GRANTED after RELOCK_CYC cycles.
module alarm_access_fsm #(
    parameter int PIN_W       = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCKOUT_CYC = 100_000_000,
    parameter int RELOCK_CYC  = 500_000_000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    alarm_access_fsm_if.slave bus
);

    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int LOCK_W = $clog2(LOCKOUT_CYC + 1);

    typedef enum logic [2:0] {
        ST_LOCKED  = 3'b000,
        ST_GRANTED = 3'b001,
        ST_DENIED  = 3'b010,
        ST_ALARM   = 3'b011
    } state_e;

    typedef enum logic [2:0] {
        EVT_NONE    = 3'd0,
        EVT_PIN_SET = 3'd1,
        EVT_GRANT   = 3'd2,
        EVT_DENY    = 3'd3,
        EVT_ALARM   = 3'd4,
        EVT_RELOCK  = 3'd5,
        EVT_IGNORED = 3'd6
    } evt_e;

    if (PIN_W < 1 || PIN_W > 16 || MAX_TRIES < 1 || MAX_TRIES > 15 ||
        LOCKOUT_CYC < 1 || RELOCK_CYC < 1) begin : g_bad_param
        $error("alarm_access_fsm: parameter out of range");
    end

    // Saturating increment of the failed-attempt count.
    function automatic logic [FAIL_W-1:0] fail_inc(input logic [FAIL_W-1:0] v);
        logic [FAIL_W-1:0] r;
        if (v >= FAIL_W'(MAX_TRIES)) begin
            r = FAIL_W'(MAX_TRIES);
        end else begin
            r = v + FAIL_W'(1);
        end
        return r;
    endfunction

    state_e            state_q,     state_d, cur_st;
    logic [FAIL_W-1:0] fail_q,      fail_d;
    logic [PIN_W-1:0]  pin_q,       pin_d;
    logic              pin_valid_q, pin_valid_d;
    logic [LOCK_W-1:0] lock_cnt_q,  lock_cnt_d;
    logic              alarm_q,     alarm_d;
    logic              evt_valid_q, evt_valid_d;
    evt_e              evt_code_q,  evt_code_d;
    logic              pin_match;
    logic              set_ok;
    logic              enter_granted;

`ifdef ALARM_RELOCK_EN
    localparam int RELOCK_W = $clog2(RELOCK_CYC + 1);
    logic [RELOCK_W-1:0] relock_cnt_q, relock_cnt_d;
`endif

    assign pin_match = (bus.i_pin == pin_q);

    // Next-state, counter and event computation for one request per cycle.
    always_comb begin
        case (state_q)
            ST_LOCKED, ST_GRANTED, ST_DENIED, ST_ALARM: cur_st = state_q;
            default:                                     cur_st = ST_LOCKED;
        endcase

        state_d       = cur_st;
        fail_d        = fail_q;
        pin_d         = pin_q;
        pin_valid_d   = pin_valid_q;
        evt_valid_d   = 1'b0;
        evt_code_d    = EVT_NONE;
        enter_granted = 1'b0;
        set_ok        = 1'b0;
        if (lock_cnt_q != LOCK_W'(0)) begin
            lock_cnt_d = lock_cnt_q - LOCK_W'(1);
        end else begin
            lock_cnt_d = LOCK_W'(0);
        end

        if (bus.i_set) begin
            evt_valid_d = 1'b1;
            if ((cur_st == ST_LOCKED && !pin_valid_q) || cur_st == ST_GRANTED) begin
                set_ok      = 1'b1;
                pin_d       = bus.i_pin;
                pin_valid_d = 1'b1;
                evt_code_d  = EVT_PIN_SET;
            end else begin
                evt_code_d  = EVT_IGNORED;
            end
        end else if (bus.i_try) begin
            if (!pin_valid_q) begin
                evt_valid_d = 1'b1;
                evt_code_d  = EVT_IGNORED;
            end else begin
                case (cur_st)
                    ST_LOCKED, ST_DENIED: begin
                        evt_valid_d = 1'b1;
                        if (pin_match) begin
                            state_d       = ST_GRANTED;
                            fail_d        = FAIL_W'(0);
                            evt_code_d    = EVT_GRANT;
                            enter_granted = 1'b1;
                        end else if (fail_inc(fail_q) == FAIL_W'(MAX_TRIES)) begin
                            fail_d     = fail_inc(fail_q);
                            state_d    = ST_ALARM;
                            lock_cnt_d = LOCK_W'(LOCKOUT_CYC);
                            evt_code_d = EVT_ALARM;
                        end else begin
                            fail_d     = fail_inc(fail_q);
                            state_d    = ST_DENIED;
                            evt_code_d = EVT_DENY;
                        end
                    end
                    ST_ALARM: begin
                        evt_valid_d = 1'b1;
                        if (lock_cnt_q != LOCK_W'(0)) begin
                            evt_code_d = EVT_IGNORED;
                        end else if (pin_match) begin
                            state_d       = ST_GRANTED;
                            fail_d        = FAIL_W'(0);
                            evt_code_d    = EVT_GRANT;
                            enter_granted = 1'b1;
                        end else begin
                            lock_cnt_d = LOCK_W'(LOCKOUT_CYC);
                            evt_code_d = EVT_DENY;
                        end
                    end
                    ST_GRANTED: begin
                        evt_valid_d = 1'b0;
                    end
                    default: begin
                        state_d = ST_LOCKED;
                    end
                endcase
            end
        end else if (bus.i_lock) begin
            evt_valid_d = 1'b1;
            if (cur_st == ST_GRANTED) begin
                state_d    = ST_LOCKED;
                fail_d     = FAIL_W'(0);
                evt_code_d = EVT_RELOCK;
            end else begin
                evt_code_d = EVT_IGNORED;
            end
        end else begin
            evt_valid_d = 1'b0;
        end

`ifdef ALARM_RELOCK_EN
        if (relock_cnt_q != RELOCK_W'(0)) begin
            relock_cnt_d = relock_cnt_q - RELOCK_W'(1);
        end else begin
            relock_cnt_d = RELOCK_W'(0);
        end
        if (enter_granted || (set_ok && cur_st == ST_GRANTED)) begin
            relock_cnt_d = RELOCK_W'(RELOCK_CYC);
        end else if (cur_st == ST_GRANTED && state_d == ST_GRANTED &&
                     relock_cnt_q <= RELOCK_W'(1)) begin
            // Timer expiry behaves like a manual relock; a coincident ignored try has no event.
            state_d      = ST_LOCKED;
            fail_d       = FAIL_W'(0);
            relock_cnt_d = RELOCK_W'(0);
            evt_valid_d  = 1'b1;
            evt_code_d   = EVT_RELOCK;
        end else begin
            relock_cnt_d = relock_cnt_d;
        end
`endif

        alarm_d = (state_d == ST_ALARM);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_LOCKED;
            fail_q      <= FAIL_W'(0);
            pin_q       <= PIN_W'(0);
            pin_valid_q <= 1'b0;
            lock_cnt_q  <= LOCK_W'(0);
            alarm_q     <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= EVT_NONE;
`ifdef ALARM_RELOCK_EN
            relock_cnt_q <= RELOCK_W'(0);
`endif
        end else begin
            state_q     <= state_d;
            fail_q      <= fail_d;
            pin_q       <= pin_d;
            pin_valid_q <= pin_valid_d;
            lock_cnt_q  <= lock_cnt_d;
            alarm_q     <= alarm_d;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
`ifdef ALARM_RELOCK_EN
            relock_cnt_q <= relock_cnt_d;
`endif
        end
    end

    assign bus.o_system_state = state_q;
    assign bus.o_fail_cnt     = 4'(fail_q);
    assign bus.o_alarm        = alarm_q;
    assign bus.o_pin_valid    = pin_valid_q;
    assign bus.o_evt_valid    = evt_valid_q;
    assign bus.o_evt_code     = evt_code_q;

endmodule
